// File: rtl/add_serial_n.sv
// -----------------------------------------------------------------------------
// add_serial_n
// Multi-cycle adder/subtractor. Two WIDTH-bit operands are combined DIGIT bits
// per clock, LSB digit first, with the carry held in a register between
// digits, so a WIDTH-bit operation takes N = WIDTH/DIGIT compute cycles.
// One operation is in flight at a time; operands come in and results go out
// through valid/ready handshakes.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand set presented
//   in_ready   block is idle and can accept operands
//   a, b       WIDTH-bit operands (unsigned or two's complement)
//   cin        carry-in (add) / borrow-in (subtract)
//   sub        0: a + b + cin, 1: a - b - cin
//   out_valid  result available
//   out_ready  consumer accepts result
//   result     sum/difference modulo 2^WIDTH
//   cout       carry out of MSB (subtract: 1 = no borrow)
//   overflow   signed overflow (carry into MSB XOR carry out of MSB)
// -----------------------------------------------------------------------------
module add_serial_n #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = $clog2(WIDTH);

  // Reject parameter sets that cannot be split into whole digits.
  if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_err
    $error("add_serial_n: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_overflow;

  logic [IW-1:0]    w_base;
  logic [DIGIT-1:0] w_a_dig;
  logic [DIGIT-1:0] w_b_dig;
  logic [DIGIT:0]   w_sum;
  logic             w_c_into_msb;
  logic             w_last;
  logic [WIDTH-1:0] w_work_next;

  // Products stay below WIDTH for every legal cnt, so IW-bit arithmetic is exact.
  assign w_base  = IW'(r_cnt) * IW'(DIGIT);
  assign w_a_dig = r_a[w_base +: DIGIT];
  assign w_b_dig = r_b[w_base +: DIGIT];
  assign w_sum   = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {{DIGIT{1'b0}}, r_carry};
  assign w_last  = (r_cnt == CW'(N - 1));

  // Carry into the digit MSB recovered from the sum bit: s = a ^ b ^ c.
  assign w_c_into_msb = w_a_dig[DIGIT-1] ^ w_b_dig[DIGIT-1] ^ w_sum[DIGIT-1];

  // Working register with the current digit merged in.
  always_comb begin
    w_work_next = r_work;
    w_work_next[w_base +: DIGIT] = w_sum[DIGIT-1:0];
  end

  // Control FSM, operand capture and digit-serial datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= {CW{1'b0}};
      r_carry    <= 1'b0;
      r_a        <= {WIDTH{1'b0}};
      r_b        <= {WIDTH{1'b0}};
      r_work     <= {WIDTH{1'b0}};
      r_result   <= {WIDTH{1'b0}};
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            // Subtract as a + ~b + ~cin so the same adder handles both modes.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? ~cin : cin;
            r_cnt   <= {CW{1'b0}};
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_work  <= w_work_next;
          r_carry <= w_sum[DIGIT];
          if (w_last) begin
            r_result   <= w_work_next;
            r_cout     <= w_sum[DIGIT];
            r_overflow <= w_c_into_msb ^ w_sum[DIGIT];
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign cout      = r_cout;
  assign overflow  = r_overflow;

endmodule

// File: doc/add_serial_n.md
# add_serial_n

Parametrised multi-cycle adder/subtractor, successor to the single-bit full adder. Adds or subtracts two WIDTH-bit operands, DIGIT bits per clock, by rippling a registered carry across WIDTH/DIGIT cycles. Operands enter and results leave through valid/ready handshakes, so the block slots into datapaths that need wide arithmetic without a wide combinational carry chain. One operation is in flight at a time.

## Interface

Parameters:
- WIDTH, 8, operand and result width in bits; WIDTH >= 2
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly (elaboration error otherwise)

Ports:
- clk  input  1  clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand set presented
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A (unsigned or two's complement)
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add) / borrow-in (subtract)
- sub  input  1  0: a + b + cin; 1: a - b - cin
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  sum/difference, modulo 2^WIDTH
- cout  output  1  carry out of MSB; in subtract mode 1 = no borrow
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB

## Operation

- State machine: IDLE, RUN, DONE. Digit counter cnt runs 0..N-1, where N = WIDTH/DIGIT.
- IDLE: in_ready = 1. At an edge with in_valid = 1, latch a, b_eff = sub ? ~b : b, and carry = sub ? ~cin : cin. Clear cnt. Go to RUN. a, b, cin and sub are sampled only at this edge.
- RUN: in_ready = 0. Each edge adds digit cnt of a, digit cnt of b_eff and the carry register. It writes the DIGIT-bit sum into digit cnt of a working register and updates carry. Digits go LSB first.
- On the edge where cnt = N-1: copy the working register to result, the final carry to cout, and (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1) to overflow. Go to DONE.
- DONE: out_valid = 1. result, cout and overflow stay stable. On an edge with out_ready = 1, go to IDLE.
- in_ready is held 0 in DONE. There is no overlap of accept and deliver.
- result, cout and overflow keep their last values after the handshake, until the next completion overwrites them.
- in_ready = (state == IDLE); out_valid = (state == DONE). Both are decoded from registered state with no combinational input-to-output paths.

## Timing

- Reset: asynchronous assertion. state = IDLE, cnt = 0, carry = 0, working register = 0, result = 0, cout = 0, overflow = 0. out_valid = 0 and in_ready = 1 immediately.
- Reset asserted during RUN or DONE aborts the operation. No result is produced and the state is IDLE after reset.
- Latency: for an operand handshake at edge E0, out_valid rises after edge E0+N. Example: WIDTH=8 with DIGIT=1 gives 8 cycles; DIGIT=4 gives 2; DIGIT=WIDTH gives 1.
- Throughput: one operation per N+2 cycles when out_ready is held at 1. The cycles are accept edge, N compute edges, and the delivery edge with in_ready returning in the following cycle.
- Backpressure: out_valid and the outputs stay constant for any number of cycles with out_ready = 0.
- While in_ready = 0, in_valid and the operand inputs are ignored. Changing them mid-RUN does not affect the result.
- A simultaneous out_ready in a non-DONE state has no effect.

## Test plan

- WIDTH=8, DIGIT=1, add: a=0x0F, b=0x01, cin=0 -> after 8 cycles result=0x10, cout=0, overflow=0.
- Signed overflow and carry: a=0x7F, b=0x01, cin=0 -> result=0x80, cout=0, overflow=1. Then a=0xFF, b=0x00, cin=1 -> result=0x00, cout=1, overflow=0.
- Subtract: sub=1, a=0x05, b=0x07, cin=0 -> result=0xFE, cout=0, overflow=0. Then a=0x80, b=0x01, cin=0 -> result=0x7F, cout=1, overflow=1.
- Backpressure and operand isolation: hold out_ready=0 for 5 cycles after out_valid -> outputs unchanged and in_ready=0 throughout. Toggle a and b during RUN -> result unaffected.
- Reset mid-operation: assert rst_n=0 at cnt=3 of a RUN -> out_valid=0, in_ready=1 and result=0 at once. A new operation 0x01+0x01 after release -> result=0x02.
- DIGIT=4 and DIGIT=8 builds: 0xA5+0x5B+cin=1 -> result=0x01, cout=1, overflow=0, with out_valid at 2 and 1 cycles after accept respectively.
